skinny64_masked_round_ctrl: RTL and testbench
=============================================

// Module: skinny64_masked_round_ctrl
// PURPOSE
//  Round engine around the 16-cell 3-share SKINNY S-box layer (4 register stages) for SKINNY-64-64.
//  - Holds the 3-share 64-bit cipher state and feeds it to the S-box layer.
//  - Consumes the S-box outputs and applies AC, ART, SR and MC per share.
//  - Writes the result back, counts rounds and returns the masked ciphertext over a valid/ready handshake.
// PARAMETERS
//  SBOX_LAT  4   register stages inside the S-box layer, from state to valid S-box output
//  ROUNDS    32  rounds per encryption (SKINNY-64-64)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   plaintext shares valid
//  in_ready     out  1   engine accepts new plaintext (state IDLE)
//  pt_s0..s2    in   64  plaintext shares; cell0 = [63:60]
//  sbox_in_s0..s2   out 64  state shares to S-box layer (direct register outputs)
//  sbox_out_s0..s2  in  64  S-box layer result shares
//  rtk_s0..s2   in   32  round-tweakey shares for rows 0-1; sampled in the writeback cycle
//  round_idx    out  6   current round, 0..ROUNDS-1; drives external tweakey schedule
//  rtk_adv      out  1   1-cycle pulse in the writeback cycle: advance tweakey schedule
//  out_valid    out  1   ciphertext shares valid
//  out_ready    in   1   consumer accepts ciphertext
//  ct_s0..s2    out  64  ciphertext shares (= state registers)
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; all state shares = 0; round_idx = 0; wait_cnt = 0.
//  - rc_lfsr = 6'h00; in_ready = 1; out_valid = 0; rtk_adv = 0.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//  - IDLE: in_valid & in_ready loads pt_s* into state; rc_lfsr and round_idx are cleared; go to RUN with wait_cnt = 0.
//  - RUN: wait_cnt counts 0..SBOX_LAT. At wait_cnt == SBOX_LAT (writeback), the per-share state becomes
//    MC(SR(ART(AC(sbox_out)))); rtk_adv = 1; wait_cnt wraps to 0. One round = SBOX_LAT+1 = 5 cycles.
//  - Round-index rule: if round_idx == ROUNDS-1 at writeback, go to DONE; otherwise round_idx += 1.
//  - The state registers stay stable for all of RUN except the writeback edge. The S-box pipeline is not flushed.
//  - DONE: out_valid = 1. out_valid & out_ready returns to IDLE.
//  - While DONE, ct_s* hold; stalls of out_ready of any length are legal.
//  - Encryption latency: ROUNDS*(SBOX_LAT+1) = 160 cycles from the load edge to out_valid.
//  Round constant:
//  - rc_lfsr is updated before use in each round: rc <= {rc[4:0], rc[5]^rc[4]^1}.
//  - Round 0 uses 6'h01, round 1 uses 6'h03, round 5 uses 6'h3E.
//  AC applies to share 0 only:
//  - cell0 ^= rc[3:0]; cell4 ^= {2'b00, rc[5:4]}; cell8 ^= 4'h2.
//  ART: share k cells 0..7 ^= rtk_sk.
//  SR: new cell i = old cell P[i], P = {0,1,2,3, 7,4,5,6, 10,11,8,9, 13,14,15,12}.
//  MC, per column (a,b,c,d): (a^c^d, a, b^c, a^c).
//  Boundary conditions:
//  - in_valid while not IDLE is ignored (in_ready = 0).
//  - out_ready while not DONE is ignored.
//  - Reset mid-RUN: all registers return to reset values immediately; no partial output is ever valid.
//  - The shares are never combined. Each share path is independent, and only the constants touch share 0.
// CONFIGURATION
//  SKINNY_STATE_CLEAR_EN
//  - Defined: on the DONE->IDLE handshake edge all state shares are zeroed, so sbox_in_s* and ct_s* read 0 in IDLE.
//  - Undefined: the state keeps the last ciphertext shares until the next load.
// STRUCTURE
//  Package skinny_masked_pkg:
//  - NUM_SHARES = 3, SR permutation table, RC_INIT = 6'h00, AC_C2 = 4'h2.
//  - Functions mix_col(), shift_rows(), rc_next().
//  - FSM state typedef {IDLE, RUN, DONE}.
//  Sub-module skinny64_lin_layer:
//  - Combinational AC/ART/SR/MC for one share, with parameter ADD_CONST (1 for share 0 only).
//  - Instantiated 3x.
// TESTING
//  Known-answer test:
//  - Setup: bench S-box layer = unmasked SKINNY-64 S-box model with SBOX_LAT delay; tweakey model fed by round_idx/rtk_adv.
//  - pt_s0 = 64'h06034f957724d19d, s1 = s2 = 0, key f5269826fc681238
//  - Expected: out_valid at cycle 160; s0^s1^s2 = 64'hbb39dfb2429b8ac7.
//  Masked input: same pt split with random s1/s2 -> XOR of ct shares = 64'hbb39dfb2429b8ac7; s1/s2 ciphertext differs from run 1.
//  Constants: with identity S-box and zero rtk, check rc used in rounds 0..5 = 01,03,07,0F,1F,3E through cell0/cell4 of share 0.
//  Handshake: out_ready held low 20 cycles -> ct_s* and out_valid stable, in_ready = 0; the out_ready pulse returns to IDLE in 1 cycle.
//  Reset mid-RUN: assert rst_n low at cycle 57 -> all outputs at reset values the same cycle.
//  Reset mid-RUN: a new load then gives the correct KAT ciphertext.
//  SKINNY_STATE_CLEAR_EN: after the output handshake sbox_in_s* == 0 when defined; equals the last ciphertext when undefined.

Source files
------------

// File: rtl/skinny_masked_pkg.sv
// Shared types, constants and linear-layer helpers for the 3-share SKINNY-64 round engine.
package skinny_masked_pkg;

  localparam int         NUM_SHARES = 3;
  localparam logic [5:0] RC_INIT    = 6'h00;
  localparam logic [3:0] AC_C2      = 4'h2;

  // Nibble i (cell 0 = MSB nibble) holds the source cell for new cell i after ShiftRows.
  localparam logic [63:0] SR_PERM = 64'h0123_7456_ab89_defc;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_state_t;

  function automatic logic [15:0] mix_col(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
    return {a ^ c ^ d, a, b ^ c, a ^ c};
  endfunction

  function automatic logic [63:0] shift_rows(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[63-4*i -: 4] = x[63-4*int'(SR_PERM[63-4*i -: 4]) -: 4];
    return y;
  endfunction

  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/skinny64_lin_layer.sv
// Combinational AC / ART / SR / MC for one share; only the share built with ADD_CONST=1 sees the round constants.
module skinny64_lin_layer
  import skinny_masked_pkg::*;
#(
  parameter bit ADD_CONST = 1'b0
) (
  input  logic [63:0] x,
  input  logic [5:0]  rc,
  input  logic [31:0] rtk,
  output logic [63:0] y
);

  logic [63:0] ac_mask;
  logic [63:0] t;
  logic [63:0] s;

  // Constants land in cells 0, 4 and 8 (first column, rows 0..2).
  assign ac_mask = ADD_CONST ? {rc[3:0], 12'h000, 2'b00, rc[5:4], 12'h000, AC_C2, 28'h0}
                             : 64'h0;
  assign t = x ^ ac_mask ^ {rtk, 32'h0};
  assign s = shift_rows(t);

  always_comb begin
    y = '0;
    for (int j = 0; j < 4; j++)
      {y[63-4*j -: 4], y[47-4*j -: 4], y[31-4*j -: 4], y[15-4*j -: 4]} =
        mix_col(s[63-4*j -: 4], s[47-4*j -: 4], s[31-4*j -: 4], s[15-4*j -: 4]);
  end

endmodule

// File: rtl/skinny64_masked_round_ctrl.sv
// Round engine around a 3-share SKINNY-64 S-box layer; optional SKINNY_STATE_CLEAR_EN zeroes the state after output.
module skinny64_masked_round_ctrl
  import skinny_masked_pkg::*;
#(
  parameter int SBOX_LAT = 4,
  parameter int ROUNDS   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pt_s0,
  input  logic [63:0] pt_s1,
  input  logic [63:0] pt_s2,
  output logic [63:0] sbox_in_s0,
  output logic [63:0] sbox_in_s1,
  output logic [63:0] sbox_in_s2,
  input  logic [63:0] sbox_out_s0,
  input  logic [63:0] sbox_out_s1,
  input  logic [63:0] sbox_out_s2,
  input  logic [31:0] rtk_s0,
  input  logic [31:0] rtk_s1,
  input  logic [31:0] rtk_s2,
  output logic [5:0]  round_idx,
  output logic        rtk_adv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ct_s0,
  output logic [63:0] ct_s1,
  output logic [63:0] ct_s2
);

  localparam int               CNT_W      = $clog2(SBOX_LAT + 1);
  localparam logic [CNT_W-1:0] WB_CNT     = CNT_W'(SBOX_LAT);
  localparam logic [5:0]       LAST_ROUND = 6'(ROUNDS - 1);

  fsm_state_t                  state_q, state_d;
  logic [NUM_SHARES-1:0][63:0] st_q;
  logic [NUM_SHARES-1:0][63:0] sb_out;
  logic [NUM_SHARES-1:0][63:0] lin_out;
  logic [NUM_SHARES-1:0][31:0] rtk;
  logic [CNT_W-1:0]            wait_cnt;
  logic [5:0]                  rc_lfsr;
  logic [5:0]                  rc_n;
  logic                        wb;

  assign sb_out = {sbox_out_s2, sbox_out_s1, sbox_out_s0};
  assign rtk    = {rtk_s2, rtk_s1, rtk_s0};
  assign rc_n   = rc_next(rc_lfsr);

  // Writeback falls on the cycle the S-box pipeline presents this round's result.
  assign wb        = (state_q == RUN) && (wait_cnt == WB_CNT);
  assign rtk_adv   = wb;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  assign sbox_in_s0 = st_q[0];
  assign sbox_in_s1 = st_q[1];
  assign sbox_in_s2 = st_q[2];
  assign ct_s0      = st_q[0];
  assign ct_s1      = st_q[1];
  assign ct_s2      = st_q[2];

  for (genvar k = 0; k < NUM_SHARES; k++) begin : g_share
    skinny64_lin_layer #(.ADD_CONST(k == 0)) u_lin (
      .x   (sb_out[k]),
      .rc  (rc_n),
      .rtk (rtk[k]),
      .y   (lin_out[k])
    );
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a missed branch would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (wb && round_idx == LAST_ROUND) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the share registers are plain flops, not RAM, so they take the async reset like any other state.
    if (!rst_n) begin
      st_q      <= '0;
      round_idx <= '0;
      wait_cnt  <= '0;
      rc_lfsr   <= RC_INIT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q      <= {pt_s2, pt_s1, pt_s0};
            round_idx <= '0;
            wait_cnt  <= '0;
            rc_lfsr   <= RC_INIT;
          end
        end
        RUN: begin
          if (wb) begin
            st_q     <= lin_out;
            rc_lfsr  <= rc_n;
            wait_cnt <= '0;
            if (round_idx != LAST_ROUND) round_idx <= round_idx + 6'd1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
`ifdef SKINNY_STATE_CLEAR_EN
          if (out_ready) st_q <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny64_masked_round_ctrl.sv
// Directed bench: KAT through a model S-box pipeline and tweakey schedule, constants, handshake and reset cases.
module tb_skinny64_masked_round_ctrl;

  localparam logic [63:0] KAT_PT  = 64'h06034f957724d19d;
  localparam logic [63:0] KAT_KEY = 64'hf5269826fc681238;
  localparam logic [63:0] KAT_CT  = 64'hbb39dfb2429b8ac7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, rtk_adv;
  logic [63:0] pt_s0, pt_s1, pt_s2;
  logic [63:0] sbox_in_s0, sbox_in_s1, sbox_in_s2;
  logic [63:0] sbox_out_s0, sbox_out_s1, sbox_out_s2;
  logic [31:0] rtk_s0, rtk_s1, rtk_s2;
  logic [5:0]  round_idx;
  logic [63:0] ct_s0, ct_s1, ct_s2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int load_cyc = 0;
  bit sb_ident = 1'b0;
  bit rtk_zero = 1'b0;
  bit mask_en  = 1'b0;

  always #5 clk = ~clk;

  skinny64_masked_round_ctrl dut (
    .clk, .rst_n, .in_valid, .in_ready, .pt_s0, .pt_s1, .pt_s2,
    .sbox_in_s0, .sbox_in_s1, .sbox_in_s2, .sbox_out_s0, .sbox_out_s1, .sbox_out_s2,
    .rtk_s0, .rtk_s1, .rtk_s2, .round_idx, .rtk_adv, .out_valid, .out_ready,
    .ct_s0, .ct_s1, .ct_s2
  );

  function automatic logic [63:0] sb_layer(input logic [63:0] x, input bit ident);
    logic [63:0] tbl;
    logic [63:0] y;
    tbl = 64'hc6901a2b385d4e7f;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[63-4*i -: 4] = tbl[63-4*int'(x[63-4*i -: 4]) -: 4];
    return ident ? x : y;
  endfunction

  function automatic logic [63:0] tk_perm(input logic [63:0] x);
    logic [63:0] p;
    logic [63:0] y;
    p = 64'h9f8daecb01234567;
    y = '0;
    for (int i = 0; i < 16; i++)
      y[63-4*i -: 4] = x[63-4*int'(p[63-4*i -: 4]) -: 4];
    return y;
  endfunction

  // Unmasked reference of AC/ART(zero)/SR/MC on share 0, written with row rotations.
  function automatic logic [63:0] ref_round_lin(input logic [63:0] x, input logic [5:0] rc);
    logic [3:0]  c [16];
    logic [3:0]  s [16];
    logic [63:0] y;
    for (int i = 0; i < 16; i++) c[i] = x[63-4*i -: 4];
    c[0] = c[0] ^ rc[3:0];
    c[4] = c[4] ^ {2'b00, rc[5:4]};
    c[8] = c[8] ^ 4'h2;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        s[4*r+j] = c[4*r + ((j - r + 4) % 4)];
    y = '0;
    for (int j = 0; j < 4; j++) begin
      y[63-4*j -: 4] = s[j] ^ s[8+j] ^ s[12+j];
      y[47-4*j -: 4] = s[j];
      y[31-4*j -: 4] = s[4+j] ^ s[8+j];
      y[15-4*j -: 4] = s[j] ^ s[8+j];
    end
    return y;
  endfunction

  // S-box layer model: recombine, substitute, re-mask with the incoming share 1/2 values.
  logic [63:0] p0 [4];
  logic [63:0] p1 [4];
  logic [63:0] p2 [4];
  always @(posedge clk) begin
    p0[0] <= sb_layer(sbox_in_s0 ^ sbox_in_s1 ^ sbox_in_s2, sb_ident) ^ sbox_in_s1 ^ sbox_in_s2;
    p1[0] <= sbox_in_s1;
    p2[0] <= sbox_in_s2;
    for (int i = 1; i < 4; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
      p2[i] <= p2[i-1];
    end
  end
  assign sbox_out_s0 = p0[3];
  assign sbox_out_s1 = p1[3];
  assign sbox_out_s2 = p2[3];

  // Tweakey schedule model (TK1 only), optionally split into three shares per round.
  logic [63:0] tk;
  logic [31:0] rm1, rm2;
  always @(posedge clk) begin
    if (in_valid && in_ready) tk <= KAT_KEY;
    else if (rtk_adv)         tk <= tk_perm(tk);
  end
  assign rm1    = mask_en ? {round_idx, 26'h2a5f3c1} : 32'h0;
  assign rm2    = mask_en ? {26'h13c7e95, round_idx} : 32'h0;
  assign rtk_s0 = (rtk_zero ? 32'h0 : tk[63:32]) ^ rm1 ^ rm2;
  assign rtk_s1 = rm1;
  assign rtk_s2 = rm2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    pt_s0 = a;
    pt_s1 = b;
    pt_s2 = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_done(output int lat);
    while (!out_valid && (cyc - load_cyc) < 400) tick();
    lat = cyc - load_cyc;
    check("done_reached", out_valid, 1);
  endtask

  task automatic handshake_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] prev, ct0, ct1, ct2, s1_run1, clr_exp, m1, m2;
    logic [5:0]  rc_tbl [6];
    bit          stable;
    int          lat;
    int          n;

    rc_tbl = '{6'h01, 6'h03, 6'h07, 6'h0f, 6'h1f, 6'h3e};
    in_valid = 1'b0;
    out_ready = 1'b0;
    pt_s0 = '0;
    pt_s1 = '0;
    pt_s2 = '0;

    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_rtk_adv", rtk_adv, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_sbox_in_s0", sbox_in_s0, 0);
    check("rst_ct_s2", ct_s2, 0);
    rst_n = 1'b1;
    tick();

    // Round constants: identity S-box, zero tweakey, all-zero state.
    sb_ident = 1'b1;
    rtk_zero = 1'b1;
    load(64'h0, 64'h0, 64'h0);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!rtk_adv && n < 10) begin
        tick();
        n++;
      end
      prev = sbox_in_s0;
      tick();
      check($sformatf("rc_round%0d", k), sbox_in_s0, ref_round_lin(prev, rc_tbl[k]));
      check($sformatf("round_idx%0d", k), round_idx, k + 1);
    end

    // Reset mid-RUN at cycle 57 after the load edge.
    while (cyc - load_cyc < 57) tick();
    check("pre_rst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_rtk_adv", rtk_adv, 0);
    check("midrst_round_idx", round_idx, 0);
    check("midrst_sbox_in_s0", sbox_in_s0, 0);
    check("midrst_ct_s0", ct_s0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Known-answer test, unmasked.
    sb_ident = 1'b0;
    rtk_zero = 1'b0;
    load(KAT_PT, 64'h0, 64'h0);
    wait_done(lat);
    check("kat_latency", lat, 160);
    check("kat_ct", ct_s0 ^ ct_s1 ^ ct_s2, KAT_CT);
    s1_run1 = ct_s1;

    // Output stall: everything holds for 20 cycles.
    ct0 = ct_s0;
    ct1 = ct_s1;
    ct2 = ct_s2;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (ct_s0 !== ct0 || ct_s1 !== ct1 || ct_s2 !== ct2 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("stall_stable", stable, 1);
    check("stall_in_ready", in_ready, 0);
    handshake_out();
    check("hs_in_ready", in_ready, 1);
    check("hs_out_valid", out_valid, 0);
`ifdef SKINNY_STATE_CLEAR_EN
    clr_exp = 64'h0;
`else
    clr_exp = ct0;
`endif
    check("idle_sbox_in_s0", sbox_in_s0, clr_exp);

    // Masked run with junk load attempts and early out_ready during RUN.
    mask_en = 1'b1;
    m1 = 64'h3c5a96e17b28d40f;
    m2 = 64'hc1e20f935a6b87d4;
    load(KAT_PT ^ m1 ^ m2, m1, m2);
    repeat (7) tick();
    in_valid = 1'b1;
    pt_s0 = 64'hffff_ffff_ffff_ffff;
    pt_s1 = 64'h1234_5678_9abc_def0;
    out_ready = 1'b1;
    tick();
    check("run_in_ready", in_ready, 0);
    check("run_out_valid", out_valid, 0);
    repeat (3) tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_done(lat);
    check("masked_ct", ct_s0 ^ ct_s1 ^ ct_s2, KAT_CT);
    check("masked_s1_differs", ct_s1 != s1_run1, 1);
    handshake_out();
    check("masked_hs_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
